pp_bank_scheduler: RTL and testbench



---
 rtl/pp_pkg.sv | 13 +
 rtl/pp_bank_scheduler_if.sv | 33 +++
 rtl/pp_bank_fsm.sv | 34 +++
 rtl/pp_bank_scheduler.sv | 146 ++++++++++++++
 tb/tb_pp_bank_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pp_pkg.sv
// Shared types and constants for the ping-pong B-operand bank scheduler.
package pp_pkg;

    localparam int NBANKS = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

endpackage

// File: rtl/pp_bank_scheduler_if.sv
// Handshake bundle between the B write/read controllers and the bank scheduler.
interface pp_bank_scheduler_if
    import pp_pkg::*;
#(
    parameter int MATRIXSIZE_W = 16
);
    logic                    start;
    logic [MATRIXSIZE_W-1:0] blocks_total;
    logic                    wr_done_early;
    logic                    wr_done;
    logic                    rd_done;
    logic [NBANKS-1:0]       bank_wr_en;
    logic [NBANKS-1:0]       bank_rd_en;
    logic                    stall_wr;
    logic [MATRIXSIZE_W-1:0] wr_blk_cnt;
    logic [MATRIXSIZE_W-1:0] rd_blk_cnt;
    logic                    busy;
    logic                    pass_done;
    logic                    err;

    modport master (
        output start, blocks_total, wr_done_early, wr_done, rd_done,
        input  bank_wr_en, bank_rd_en, stall_wr, wr_blk_cnt, rd_blk_cnt,
               busy, pass_done, err
    );

    modport slave (
        input  start, blocks_total, wr_done_early, wr_done, rd_done,
        output bank_wr_en, bank_rd_en, stall_wr, wr_blk_cnt, rd_blk_cnt,
               busy, pass_done, err
    );

endinterface

// File: rtl/pp_bank_fsm.sv
// Lifecycle of one buffer bank: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY.
module pp_bank_fsm
    import pp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        claim_wr,
    input  logic        wr_done,
    input  logic        claim_rd,
    input  logic        rd_done,
    output bank_state_t state
);

    bank_state_t state_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Transitions; a bank drained this cycle can be reclaimed by the writer in the same edge.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (claim_wr) state_next = FILL;
            FILL:    if (wr_done)  state_next = FULL;
            FULL:    if (claim_rd) state_next = DRAIN;
            DRAIN:   if (rd_done)  state_next = claim_wr ? FILL : EMPTY;
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: rtl/pp_bank_scheduler.sv
// Two-bank ping-pong scheduler: write/read pointers, block counters, stall and error logic.
module pp_bank_scheduler
    import pp_pkg::*;
#(
    parameter int MATRIXSIZE_W = 16
)(
    input logic                clk,
    input logic                rst,
    pp_bank_scheduler_if.slave bus
);

    bank_state_t             state [NBANKS];
    logic                    wp, rp, wp_next, rp_next;
    logic [MATRIXSIZE_W-1:0] total, total_next;
    logic [MATRIXSIZE_W-1:0] wr_cnt, wr_cnt_next, rd_cnt, rd_cnt_next;
    logic                    busy, busy_next, pass_done, pass_done_next;
    logic                    err, err_next, early_q, stall, stall_next;
    logic                    wr_ok, rd_ok, grant, stall_force;
    logic [NBANKS-1:0]       fill_now, drain_now, fill_next, drain_next;
    logic [NBANKS-1:0]       claim_wr, claim_rd, bank_wr_done, bank_rd_done;
    logic [NBANKS-1:0]       wr_en, rd_en;

    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        pp_bank_fsm u_fsm (
            .clk      (clk),
            .rst      (rst),
            .claim_wr (claim_wr[g]),
            .wr_done  (bank_wr_done[g]),
            .claim_rd (claim_rd[g]),
            .rd_done  (bank_rd_done[g]),
            .state    (state[g])
        );
    end

    // Pass control: qualify done pulses, advance pointers/counters, pick banks to claim.
    always_comb begin
        wp_next        = wp;
        rp_next        = rp;
        total_next     = total;
        wr_cnt_next    = wr_cnt;
        rd_cnt_next    = rd_cnt;
        busy_next      = busy;
        pass_done_next = 1'b0;
        err_next       = err;
        claim_wr       = '0;
        claim_rd       = '0;
        bank_wr_done   = '0;
        bank_rd_done   = '0;
        for (int unsigned i = 0; i < NBANKS; i++) begin
            fill_now[i]  = (state[i] == FILL);
            drain_now[i] = (state[i] == DRAIN);
        end

        wr_ok       = bus.wr_done && busy && fill_now[wp];
        rd_ok       = bus.rd_done && busy && drain_now[rp];
        grant       = busy && (drain_now == '0) && (state[rp] == FULL);
        stall_force = bus.wr_done_early && (state[~wp] != EMPTY);

        if (bus.wr_done && !wr_ok)       err_next = 1'b1;
        if (bus.rd_done && !rd_ok)       err_next = 1'b1;
        if (early_q && !bus.wr_done)     err_next = 1'b1;

        if (bus.start) begin
            if (busy) begin
                err_next = 1'b1;
            end else begin
                total_next  = bus.blocks_total;
                wr_cnt_next = '0;
                rd_cnt_next = '0;
                wp_next     = 1'b0;
                rp_next     = 1'b0;
                if (bus.blocks_total != '0) busy_next      = 1'b1;
                else                        pass_done_next = 1'b1;
            end
        end

        if (grant) claim_rd[rp] = 1'b1;

        if (wr_ok) begin
            bank_wr_done[wp] = 1'b1;
            wr_cnt_next      = wr_cnt + 1'b1;
            wp_next          = ~wp;
        end

        if (rd_ok) begin
            bank_rd_done[rp] = 1'b1;
            rd_cnt_next      = rd_cnt + 1'b1;
            rp_next          = ~rp;
            if (rd_cnt_next == total) begin
                pass_done_next = 1'b1;
                busy_next      = 1'b0;
            end
        end

        // The writer's next bank is claimed whether it was already empty or is being freed now.
        if (busy_next && (wr_cnt_next < total_next) &&
            ((state[wp_next] == EMPTY) || bank_rd_done[wp_next]))
            claim_wr[wp_next] = 1'b1;

        fill_next  = claim_wr | (fill_now & ~bank_wr_done);
        drain_next = claim_rd | (drain_now & ~bank_rd_done);
        stall_next = !busy_next || (fill_next == '0) ||
                     (wr_cnt_next >= total_next) || stall_force;
    end

    // Registered control state and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= 1'b0;
            rp        <= 1'b0;
            total     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
            err       <= 1'b0;
            early_q   <= 1'b0;
            stall     <= 1'b1;
            wr_en     <= '0;
            rd_en     <= '0;
        end else begin
            wp        <= wp_next;
            rp        <= rp_next;
            total     <= total_next;
            wr_cnt    <= wr_cnt_next;
            rd_cnt    <= rd_cnt_next;
            busy      <= busy_next;
            pass_done <= pass_done_next;
            err       <= err_next;
            early_q   <= bus.wr_done_early;
            stall     <= stall_next;
            wr_en     <= fill_next;
            rd_en     <= drain_next;
        end
    end

    assign bus.bank_wr_en = wr_en;
    assign bus.bank_rd_en = rd_en;
    assign bus.stall_wr   = stall;
    assign bus.wr_blk_cnt = wr_cnt;
    assign bus.rd_blk_cnt = rd_cnt;
    assign bus.busy       = busy;
    assign bus.pass_done  = pass_done;
    assign bus.err        = err;

endmodule

// File: tb/tb_pp_bank_scheduler.sv
// Self-checking bench for pp_bank_scheduler: directed scenarios plus randomized passes
// compared every cycle against a rule-level reference model.
module tb_pp_bank_scheduler;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pp_bank_scheduler_if #(.MATRIXSIZE_W(W)) bus ();

    pp_bank_scheduler #(.MATRIXSIZE_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: bank states 0=empty 1=fill 2=full 3=drain.
    int m_st[2];
    int m_wp, m_rp, m_total, m_wc, m_rc;
    bit m_busy, m_pd, m_err, m_eq, m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rs, input bit s, input int bt, input bit e, input bit w, input bit r);
        int nst[2];
        bit wok, rok, grant, nforce, npd;
        if (rs) begin
            m_st[0] = 0; m_st[1] = 0; m_wp = 0; m_rp = 0; m_total = 0; m_wc = 0; m_rc = 0;
            m_busy = 0; m_pd = 0; m_err = 0; m_eq = 0; m_stall = 1;
            return;
        end
        nst[0] = m_st[0];
        nst[1] = m_st[1];
        wok    = w && m_busy && m_st[m_wp] == 1;
        rok    = r && m_busy && m_st[m_rp] == 3;
        grant  = m_busy && m_st[0] != 3 && m_st[1] != 3 && m_st[m_rp] == 2;
        nforce = e && m_st[1 - m_wp] != 0;
        npd    = 0;
        if ((w && !wok) || (r && !rok) || (m_eq && !w)) m_err = 1;
        if (s) begin
            if (m_busy) m_err = 1;
            else begin
                m_total = bt; m_wc = 0; m_rc = 0; m_wp = 0; m_rp = 0;
                if (bt > 0) begin m_busy = 1; nst[0] = 1; end
                else npd = 1;
            end
        end
        if (grant) nst[m_rp] = 3;
        if (wok) begin nst[m_wp] = 2; m_wc++; m_wp = 1 - m_wp; end
        if (rok) begin
            nst[m_rp] = 0; m_rc++; m_rp = 1 - m_rp;
            if (m_rc == m_total) begin m_busy = 0; npd = 1; end
        end
        if (m_busy && m_wc < m_total && nst[m_wp] == 0) nst[m_wp] = 1;
        m_stall = !m_busy || (nst[0] != 1 && nst[1] != 1) || m_wc >= m_total || nforce;
        m_st[0] = nst[0];
        m_st[1] = nst[1];
        m_pd    = npd;
        m_eq    = e;
    endtask

    task automatic compare_all();
        logic [1:0] exp_wr, exp_rd;
        exp_wr = {m_st[1] == 1, m_st[0] == 1};
        exp_rd = {m_st[1] == 3, m_st[0] == 3};
        chk("bank_wr_en", bus.bank_wr_en, exp_wr);
        chk("bank_rd_en", bus.bank_rd_en, exp_rd);
        chk("stall_wr",   bus.stall_wr,   m_stall);
        chk("wr_blk_cnt", bus.wr_blk_cnt, m_wc);
        chk("rd_blk_cnt", bus.rd_blk_cnt, m_rc);
        chk("busy",       bus.busy,       m_busy);
        chk("pass_done",  bus.pass_done,  m_pd);
        chk("err",        bus.err,        m_err);
    endtask

    task automatic step(input bit rs, input bit s, input int bt, input bit e, input bit w, input bit r);
        rst                = rs;
        bus.start          = s;
        bus.blocks_total   = W'(bt);
        bus.wr_done_early  = e;
        bus.wr_done        = w;
        bus.rd_done        = r;
        @(posedge clk);
        model(rs, s, bt, e, w, r);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Legal random traffic until the model reports the pass finished, bounded by budget.
    task automatic drain_pass(input int budget);
        bit pend;
        bit e, w, r;
        pend = 0;
        for (int c = 0; c < budget && m_busy; c++) begin
            e = 0; w = 0; r = 0;
            if (pend) begin
                w = 1; pend = 0;
            end else if ((m_st[0] == 1 || m_st[1] == 1) && $urandom_range(0, 2) == 0) begin
                e = 1; pend = 1;
            end
            if ((m_st[0] == 3 || m_st[1] == 3) && $urandom_range(0, 1) == 0) r = 1;
            step(0, 0, 0, e, w, r);
        end
        chk("pass_end_busy", bus.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_stall", bus.stall_wr, 1);
        chk("rst_wr_en", bus.bank_wr_en, 0);
        chk("rst_busy",  bus.busy, 0);

        // Single-block pass
        step(0, 1, 1, 0, 0, 0);
        chk("t1_wr_en", bus.bank_wr_en, 2'b01);
        chk("t1_stall", bus.stall_wr, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("t1_rd_en_t1", bus.bank_rd_en, 2'b00);
        idle();
        chk("t1_rd_en_t2", bus.bank_rd_en, 2'b01);
        step(0, 0, 0, 0, 0, 1);
        chk("t1_pass_done", bus.pass_done, 1);
        chk("t1_busy", bus.busy, 0);
        idle();

        // Four blocks, slow reader, early-done stall
        step(0, 1, 4, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("t2_wr_en_bank1", bus.bank_wr_en, 2'b10);
        idle();
        step(0, 0, 0, 1, 0, 0);
        chk("t2_early_stall", bus.stall_wr, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("t2_stall_2nd", bus.stall_wr, 1);
        idle(); idle(); idle();
        chk("t2_stall_hold", bus.stall_wr, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t2_refill", bus.bank_wr_en, 2'b01);
        chk("t2_unstall", bus.stall_wr, 0);
        drain_pass(300);
        chk("t2_rd_cnt", bus.rd_blk_cnt, 4);

        // Same-cycle wr_done (bank 1) and rd_done (bank 0)
        step(0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle();
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("t3_wr_en", bus.bank_wr_en, 2'b01);
        chk("t3_rd_en", bus.bank_rd_en, 2'b00);
        chk("t3_err", bus.err, 0);
        idle();
        chk("t3_grant_b1", bus.bank_rd_en, 2'b10);
        drain_pass(300);

        // Randomized passes
        for (int p = 0; p < 6; p++) begin
            step(0, 1, int'($urandom_range(1, 6)), 0, 0, 0);
            drain_pass(400);
        end

        // Protocol violations
        step(0, 0, 0, 0, 0, 1);
        chk("t4_rd_idle_err", bus.err, 1);
        step(0, 1, 2, 0, 0, 0);
        drain_pass(300);
        chk("t4_err_sticky", bus.err, 1);
        step(0, 1, 2, 0, 0, 0);
        step(0, 1, 5, 0, 0, 0);
        chk("t4_start_busy_err", bus.err, 1);
        drain_pass(300);
        chk("t4_total_kept", bus.rd_blk_cnt, 2);

        // Reset mid-pass, then a clean two-block pass
        step(0, 1, 4, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle();
        chk("t5_both_busy", {bus.bank_wr_en, bus.bank_rd_en}, 4'b1001);
        step(1, 0, 0, 0, 0, 0);
        chk("t5_rst_wr_en", bus.bank_wr_en, 0);
        chk("t5_rst_rd_en", bus.bank_rd_en, 0);
        chk("t5_rst_stall", bus.stall_wr, 1);
        chk("t5_rst_err", bus.err, 0);
        step(0, 1, 2, 0, 0, 0);
        drain_pass(300);
        chk("t5_rd_cnt", bus.rd_blk_cnt, 2);
        chk("t5_err_clean", bus.err, 0);

        // Orphan early-done, then zero-length pass
        step(0, 0, 0, 1, 0, 0);
        idle();
        chk("t6_orphan_early", bus.err, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("t6_zero_pass_done", bus.pass_done, 1);
        chk("t6_zero_busy", bus.busy, 0);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
